// File: rtl/pcie_lane_striper.sv
// Byte-to-lane striper: packs a MAC byte stream into W-lane words, PAD-closes partial words on flush.
// Optional SKP insertion every SKP_INTERVAL data words is compiled in with `define PCIE_STRIPER_SKP_EN.
module pcie_lane_striper #(
    parameter int NUM_LANES    = 4,
    parameter int SKP_INTERVAL = 1180
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [4:0]             link_width_i,
    input  logic [7:0]             mac_data_frame_i,
    input  logic                   mac_data_frame_valid_i,
    output logic                   mac_data_frame_ready_o,
    input  logic                   flush_i,
    output logic [NUM_LANES*8-1:0] lane_data_o,
    output logic [NUM_LANES-1:0]   lane_k_o,
    output logic                   lane_valid_o,
    input  logic                   lane_ready_i
);
    localparam logic [7:0] PAD_SYM = 8'hF7;
    localparam logic [7:0] SKP_SYM = 8'h1C;

    if (!(NUM_LANES inside {1, 2, 4, 8, 16}) || SKP_INTERVAL < 2 || SKP_INTERVAL > 4095) begin : g_bad_param
        $error("pcie_lane_striper: illegal NUM_LANES or SKP_INTERVAL");
    end

    typedef enum logic [1:0] {IDLE, FILL, SKP} state_t;

    state_t                    state, state_next;
    logic [4:0]                width_q;
    logic [4:0]                lane_idx;
    logic                      flush_q;
    logic [NUM_LANES-1:0][7:0] asm_data;
    logic [NUM_LANES-1:0][7:0] word_data;
    logic [NUM_LANES-1:0]      word_k;
    logic                      idx_end, can_load, pad_req, byte_acc, word_done;
    logic                      skp_hold, skp_load, skp_done;

    function automatic logic legal_width(input logic [4:0] w);
        return (w == 5'd1 || w == 5'd2 || w == 5'd4 || w == 5'd8 || w == 5'd16) &&
               (int'(w) <= NUM_LANES);
    endfunction

    assign idx_end  = (lane_idx == width_q - 5'd1);
    assign can_load = !lane_valid_o || lane_ready_i;
    // A flush seen while the output is blocked is remembered in flush_q until the word can load.
    assign pad_req  = (state == FILL) && (flush_i || flush_q) && (lane_idx != 5'd0);

    assign mac_data_frame_ready_o = (state == FILL) && !skp_hold && !flush_q &&
                                    !((idx_end || pad_req) && !can_load);
    assign byte_acc  = mac_data_frame_valid_i && mac_data_frame_ready_o;
    assign word_done = (byte_acc && idx_end) || (pad_req && can_load);

`ifdef PCIE_STRIPER_SKP_EN
    logic [11:0] skp_cnt;
    logic        skp_pending;
    logic        out_skp;

    assign skp_hold = skp_pending && (lane_idx == 5'd0);
    assign skp_load = (state == SKP) && !(lane_valid_o && out_skp) && can_load;
    assign skp_done = (state == SKP) && lane_valid_o && out_skp && lane_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skp_cnt     <= '0;
            skp_pending <= 1'b0;
            out_skp     <= 1'b0;
        end else begin
            if (skp_done) begin
                skp_cnt     <= '0;
                skp_pending <= 1'b0;
            end else if (lane_valid_o && lane_ready_i && !out_skp && !skp_pending) begin
                skp_cnt <= skp_cnt + 12'd1;
                if (skp_cnt + 12'd1 == 12'(SKP_INTERVAL)) skp_pending <= 1'b1;
            end
            if (word_done)                        out_skp <= 1'b0;
            else if (skp_load)                    out_skp <= 1'b1;
            else if (lane_valid_o && lane_ready_i) out_skp <= 1'b0;
        end
    end
`else
    assign skp_hold = 1'b0;
    assign skp_load = 1'b0;
    assign skp_done = 1'b0;
`endif

    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        word_data = '0;
        word_k    = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            if (n < int'(lane_idx)) begin
                word_data[n] = asm_data[n];
            end else if (n == int'(lane_idx) && byte_acc) begin
                word_data[n] = mac_data_frame_i;
            end else if (n < int'(width_q)) begin
                word_data[n] = PAD_SYM;
                word_k[n]    = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (legal_width(link_width_i)) state_next = FILL;
            FILL:    if (skp_hold) state_next = SKP;
            SKP:     if (skp_done) state_next = FILL;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the assembly buffer has no reset; lane_idx alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < NUM_LANES; n++) begin
            if (byte_acc && n == int'(lane_idx)) asm_data[n] <= mac_data_frame_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            width_q      <= '0;
            lane_idx     <= '0;
            flush_q      <= 1'b0;
            lane_valid_o <= 1'b0;
            lane_data_o  <= '0;
            lane_k_o     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) width_q <= link_width_i;

            if (word_done)     lane_idx <= '0;
            else if (byte_acc) lane_idx <= lane_idx + 5'd1;
            flush_q <= pad_req && !word_done;

            if (word_done) begin
                lane_data_o  <= word_data;
                lane_k_o     <= word_k;
                lane_valid_o <= 1'b1;
            end else if (skp_load) begin
                for (int n = 0; n < NUM_LANES; n++) begin
                    lane_data_o[8*n +: 8] <= (n < int'(width_q)) ? SKP_SYM : 8'h00;
                    lane_k_o[n]           <= (n < int'(width_q));
                end
                lane_valid_o <= 1'b1;
            end else if (lane_ready_i) begin
                lane_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pcie_lane_striper.sv
// Scoreboard bench for pcie_lane_striper: a byte-level model predicts every output word.
// Build with +define+PCIE_STRIPER_SKP_EN to also check SKP insertion (SKP_INTERVAL=3).
module tb_pcie_lane_striper;
    localparam int NUM_LANES    = 4;
    localparam int SKP_INTERVAL = 3;
    localparam int WB           = NUM_LANES * 9;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic [4:0]             link_width_i;
    logic [7:0]             mac_data_frame_i;
    logic                   mac_data_frame_valid_i;
    logic                   mac_data_frame_ready_o;
    logic                   flush_i;
    logic [NUM_LANES*8-1:0] lane_data_o;
    logic [NUM_LANES-1:0]   lane_k_o;
    logic                   lane_valid_o;
    logic                   lane_ready_i;

    always #5 clk_i = ~clk_i;

    pcie_lane_striper #(.NUM_LANES(NUM_LANES), .SKP_INTERVAL(SKP_INTERVAL)) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .link_width_i           (link_width_i),
        .mac_data_frame_i       (mac_data_frame_i),
        .mac_data_frame_valid_i (mac_data_frame_valid_i),
        .mac_data_frame_ready_o (mac_data_frame_ready_o),
        .flush_i                (flush_i),
        .lane_data_o            (lane_data_o),
        .lane_k_o               (lane_k_o),
        .lane_valid_o           (lane_valid_o),
        .lane_ready_i           (lane_ready_i)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model state: bytes of the word being assembled and words still owed downstream.
    logic [7:0]    partial[$];
    logic [WB-1:0] exp_q[$];
    int            cur_w = 4;
    bit            active = 0;
    bit            flush_wait = 0;
    bit            lat_pending = 0;
    logic [WB-1:0] lat_word;
    bit            prev_hold = 0;
    logic [WB-1:0] held;
    int            data_since_skp = 0;
    int            skp_seen = 0;

    function automatic logic [WB-1:0] make_word();
        logic [NUM_LANES-1:0]   k = '0;
        logic [NUM_LANES*8-1:0] d = '0;
        for (int n = 0; n < cur_w; n++) begin
            if (n < partial.size()) d[8*n +: 8] = partial[n];
            else begin
                d[8*n +: 8] = 8'hF7;
                k[n]        = 1'b1;
            end
        end
        return {k, d};
    endfunction

    function automatic logic [WB-1:0] skp_word();
        logic [NUM_LANES-1:0]   k = '0;
        logic [NUM_LANES*8-1:0] d = '0;
        for (int n = 0; n < cur_w; n++) begin
            d[8*n +: 8] = 8'h1C;
            k[n]        = 1'b1;
        end
        return {k, d};
    endfunction

    task automatic emit();
        lat_word = make_word();
        exp_q.push_back(lat_word);
        lat_pending = 1;
        partial.delete();
        flush_wait = 0;
    endtask

    // Monitor: samples mid-cycle, between the driver's updates and the next active edge.
    always @(negedge clk_i) begin
        logic can_load, exp_ready, fl;
        int   sz;
        if (!rst_ni) begin
            partial.delete();
            exp_q.delete();
            flush_wait     = 0;
            lat_pending    = 0;
            prev_hold      = 0;
            data_since_skp = 0;
        end else begin
            if (lat_pending) begin
                check("latency_valid", 64'(lane_valid_o), 64'd1);
                check("latency_word", 64'({lane_k_o, lane_data_o}), 64'(lat_word));
                lat_pending = 0;
            end
            if (prev_hold)
                check("hold_stable", 64'({lane_valid_o, lane_k_o, lane_data_o}), 64'({1'b1, held}));
            prev_hold = lane_valid_o && !lane_ready_i;
            held      = {lane_k_o, lane_data_o};

`ifdef PCIE_STRIPER_SKP_EN
            if (lane_valid_o && lane_k_o[0])
                check("skp_ready_low", 64'(mac_data_frame_ready_o), 64'd0);
`endif
            if (lane_valid_o && lane_ready_i) begin
`ifdef PCIE_STRIPER_SKP_EN
                if (lane_k_o[0]) begin
                    check("skp_word", 64'({lane_k_o, lane_data_o}), 64'(skp_word()));
                    check("skp_spacing_min", 64'(data_since_skp >= SKP_INTERVAL), 64'd1);
                    data_since_skp = 0;
                    skp_seen++;
                end else
`endif
                begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %0h, expected no word", {lane_k_o, lane_data_o});
                    end else begin
                        check("word", 64'({lane_k_o, lane_data_o}), 64'(exp_q.pop_front()));
                    end
`ifdef PCIE_STRIPER_SKP_EN
                    data_since_skp++;
                    check("skp_spacing_max", 64'(data_since_skp <= SKP_INTERVAL + 1), 64'd1);
`endif
                end
            end

            if (active) begin
                can_load = !lane_valid_o || lane_ready_i;
                sz       = partial.size();
                fl       = (flush_i || flush_wait) && sz > 0;
                if (flush_wait || (fl && !can_load)) exp_ready = 0;
                else if (sz == cur_w - 1)            exp_ready = can_load;
                else                                 exp_ready = 1;
`ifdef PCIE_STRIPER_SKP_EN
                if (!exp_ready) check("ready_rule", 64'(mac_data_frame_ready_o), 64'd0);
`else
                check("ready_rule", 64'(mac_data_frame_ready_o), 64'(exp_ready));
`endif
                if (mac_data_frame_valid_i && mac_data_frame_ready_o) partial.push_back(mac_data_frame_i);
                if (partial.size() == cur_w) emit();
                else if (fl) begin
                    if (can_load) emit();
                    else flush_wait = 1;
                end
            end
        end
    end

    task automatic wait_accept();
        int t = 0;
        forever begin
            @(negedge clk_i);
            if (mac_data_frame_ready_o) break;
            t++;
            if (t > 300) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: got no ready after %0d cycles, expected ready", t);
                break;
            end
        end
        @(posedge clk_i); #1;
        mac_data_frame_valid_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        mac_data_frame_valid_i = 1'b1;
        mac_data_frame_i       = b;
        wait_accept();
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
    endtask

    task automatic run_random(input int cycles);
        logic acc;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_i);
            acc = mac_data_frame_valid_i && mac_data_frame_ready_o;
            @(posedge clk_i); #1;
            if (acc || !mac_data_frame_valid_i) begin
                mac_data_frame_valid_i = ($urandom_range(0, 3) != 0);
                mac_data_frame_i       = 8'($urandom);
            end
            flush_i      = ($urandom_range(0, 15) == 0);
            lane_ready_i = ($urandom_range(0, 9) < 7);
        end
        mac_data_frame_valid_i = 1'b0;
        flush_i                = 1'b0;
        lane_ready_i           = 1'b1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_lane_valid"}, 64'(lane_valid_o), 64'd0);
        check({tag, "_ready"},      64'(mac_data_frame_ready_o), 64'd0);
        check({tag, "_lane_data"},  64'(lane_data_o), 64'd0);
        check({tag, "_lane_k"},     64'(lane_k_o), 64'd0);
    endtask

    task automatic restart(input logic [4:0] w);
        active = 0;
        @(posedge clk_i); #3;
        rst_ni = 1'b0;
        #1;
        reset_checks("async_reset");
        repeat (2) @(posedge clk_i);
        #1;
        link_width_i = w;
        cur_w        = int'(w);
        rst_ni       = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        active = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        mac_data_frame_valid_i = 1'b0;
        mac_data_frame_i       = '0;
        flush_i                = 1'b0;
        lane_ready_i           = 1'b1;
        link_width_i           = 5'd4;
        repeat (3) @(posedge clk_i);
        #1;
        reset_checks("reset");

        // Illegal widths keep the block in IDLE even with a byte offered.
        link_width_i           = 5'd3;
        rst_ni                 = 1'b1;
        mac_data_frame_valid_i = 1'b1;
        mac_data_frame_i       = 8'h55;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        check("idle_w3_ready", 64'(mac_data_frame_ready_o), 64'd0);
        check("idle_w3_valid", 64'(lane_valid_o), 64'd0);
        link_width_i = 5'd8;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("idle_w8_ready", 64'(mac_data_frame_ready_o), 64'd0);
        @(posedge clk_i); #1;
        mac_data_frame_valid_i = 1'b0;
        link_width_i           = 5'd4;
        cur_w                  = 4;
        repeat (2) @(posedge clk_i);
        #1;
        active = 1;

        for (int b = 1; b <= 8; b++) send_byte(8'(b));
        repeat (3) @(posedge clk_i);
        #1;

        send_byte(8'h11);
        send_byte(8'h22);
        pulse_flush();
        repeat (3) @(posedge clk_i);
        #1;

        // Width changes outside IDLE are ignored; the model keeps W=4.
        link_width_i = 5'd2;
        lane_ready_i = 1'b0;
        for (int b = 0; b < 7; b++) send_byte(8'h21 + 8'(b));
        mac_data_frame_valid_i = 1'b1;
        mac_data_frame_i       = 8'h28;
        repeat (5) begin
            @(negedge clk_i);
            check("bp_ready_low", 64'(mac_data_frame_ready_o), 64'd0);
        end
        @(posedge clk_i); #1;
        lane_ready_i = 1'b1;
        wait_accept();
        repeat (3) @(posedge clk_i);
        #1;

        run_random(800);
        pulse_flush();
        repeat (6) @(posedge clk_i);
        #1;

        // Reset with a partial word in assembly; the W=2 word afterwards must not carry it.
        send_byte(8'h91);
        send_byte(8'h92);
        restart(5'd2);
        send_byte(8'hAB);
        send_byte(8'hCD);
        repeat (3) @(posedge clk_i);
        #1;
        run_random(400);
        pulse_flush();
        repeat (6) @(posedge clk_i);
        #1;

        restart(5'd1);
        run_random(300);
        repeat (10) @(posedge clk_i);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
`ifdef PCIE_STRIPER_SKP_EN
        check("skp_seen", 64'(skp_seen > 0), 64'd1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
